// File: rtl/row_request_scheduler_pkg.sv
// Shared types and constants for the row-request scheduler and the AXIS row-request generator.
package row_request_scheduler_pkg;

    localparam int          CNT_W                    = 64;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES   = 1_000_000;
    localparam int          MAX_OUTSTANDING_REQUESTS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_ACK,
        ST_WAIT_GEN,
        ST_DRAIN,
        ST_NEXT,
        ST_DONE,
        ST_ABORT_WAIT
    } state_t;

endpackage

// File: rtl/sched_watchdog.sv
// Completion watchdog: counts enabled cycles since the last clear and flags expiry
// on the cycle that would make TIMEOUT_CYCLES idle cycles (TIMEOUT_CYCLES must be >= 1).
module sched_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = row_request_scheduler_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [31:0] count;

    assign expired = enable && !clear && (count >= TIMEOUT_CYCLES - 32'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/row_request_scheduler.sv
// Splits a row transfer into generator-sized chunks, repeats it per frame, and tracks
// completions, status flags and a completion watchdog.
module row_request_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = row_request_scheduler_pkg::DEFAULT_TIMEOUT_CYCLES,
    parameter int          CNT_W          = row_request_scheduler_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_total_rows,
    input  logic [31:0]      cfg_chunk_rows,
    input  logic [15:0]      cfg_frames,
    output logic             gen_start,
    output logic [CNT_W-1:0] gen_count,
    input  logic             gen_idle,
    input  logic             row_complete_in,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err_cfg,
    output logic             err_timeout,
    output logic             err_overrun,
    output logic [CNT_W-1:0] rows_done,
    output logic [15:0]      frames_done
);
    import row_request_scheduler_pkg::*;

    state_t           state, state_next;
    logic [CNT_W-1:0] total_rows_r;
    logic [31:0]      chunk_rows_r;
    logic [15:0]      frames_r;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] chunk_outstanding;
    logic             ack_passed;

    logic             counting_state;
    logic [CNT_W-1:0] chunk_ext;
    logic [CNT_W-1:0] chunk;
    logic             count_row;
    logic             overrun_row;
    logic             drained;
    logic [16:0]      frames_next;
    logic             last_frame;
    logic             start_ok;
    logic             abortable;
    logic             wd_expired;

    assign busy           = (state != ST_IDLE);
    assign counting_state = state inside {ST_WAIT_ACK, ST_WAIT_GEN, ST_DRAIN};
    assign chunk_ext      = {{(CNT_W-32){1'b0}}, chunk_rows_r};
    assign chunk          = (remaining < chunk_ext) ? remaining : chunk_ext;
    assign count_row      = row_complete_in && counting_state && (chunk_outstanding != '0);
    assign overrun_row    = row_complete_in && busy && (chunk_outstanding == '0);
    // A final completion arriving on the cycle DRAIN exits is still counted.
    assign drained        = (chunk_outstanding == '0) ||
                            ((chunk_outstanding == CNT_W'(1)) && row_complete_in);
    assign frames_next    = {1'b0, frames_done} + 17'd1;
    assign last_frame     = (frames_next == {1'b0, frames_r});
    assign start_ok       = start && !abort;
    assign abortable      = state inside {ST_LAUNCH, ST_WAIT_ACK, ST_WAIT_GEN, ST_DRAIN, ST_NEXT};

    sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (row_complete_in || !counting_state),
        .enable  (counting_state),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    if (cfg_total_rows == '0)       state_next = ST_DONE;
                    else if (cfg_chunk_rows != '0)  state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH:   state_next = abort ? ST_IDLE : ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (abort)           state_next = ST_ABORT_WAIT;
                else if (wd_expired) state_next = ST_IDLE;
                else if (!gen_idle)  state_next = ST_WAIT_GEN;
            end
            ST_WAIT_GEN: begin
                if (abort)           state_next = ST_ABORT_WAIT;
                else if (wd_expired) state_next = ST_IDLE;
                else if (gen_idle)   state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort || wd_expired) state_next = ST_IDLE;
                else if (drained)        state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (abort)                  state_next = ST_IDLE;
                else if (remaining != '0)   state_next = ST_LAUNCH;
                else if (last_frame)        state_next = ST_DONE;
                else                        state_next = ST_LAUNCH;
            end
            ST_DONE:       state_next = ST_IDLE;
            ST_ABORT_WAIT: if (ack_passed && gen_idle) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // NOTE: every datapath register is asynchronously cleared; none of this is memory.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            total_rows_r      <= '0;
            chunk_rows_r      <= '0;
            frames_r          <= '0;
            remaining         <= '0;
            chunk_outstanding <= '0;
            ack_passed        <= 1'b0;
            gen_start         <= 1'b0;
            gen_count         <= '0;
            done              <= 1'b0;
            aborted           <= 1'b0;
            err_cfg           <= 1'b0;
            err_timeout       <= 1'b0;
            err_overrun       <= 1'b0;
            rows_done         <= '0;
            frames_done       <= '0;
        end else begin
            gen_start <= 1'b0;
            done      <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        total_rows_r      <= cfg_total_rows;
                        chunk_rows_r      <= cfg_chunk_rows;
                        frames_r          <= (cfg_frames == 16'd0) ? 16'd1 : cfg_frames;
                        remaining         <= cfg_total_rows;
                        chunk_outstanding <= '0;
                        aborted           <= 1'b0;
                        err_timeout       <= 1'b0;
                        err_overrun       <= 1'b0;
                        err_cfg           <= (cfg_chunk_rows == '0) && (cfg_total_rows != '0);
                        rows_done         <= '0;
                        frames_done       <= '0;
                    end
                end
                ST_LAUNCH: begin
                    if (!abort) begin
                        gen_start         <= 1'b1;
                        gen_count         <= chunk;
                        remaining         <= remaining - chunk;
                        chunk_outstanding <= chunk;
                        ack_passed        <= 1'b0;
                    end
                end
                ST_NEXT: begin
                    if (!abort && remaining == '0) begin
                        frames_done <= frames_next[15:0];
                        if (!last_frame) remaining <= total_rows_r;
                    end
                end
                ST_DONE: begin
                    done        <= 1'b1;
                    frames_done <= frames_r;
                end
                default: ;
            endcase

            // The generator has no stop input, so an abort must see it go busy before trusting idle.
            if ((state == ST_WAIT_ACK || state == ST_ABORT_WAIT) && !gen_idle) ack_passed <= 1'b1;

            if (count_row) begin
                chunk_outstanding <= chunk_outstanding - CNT_W'(1);
                rows_done         <= rows_done + CNT_W'(1);
            end
            if (overrun_row)          err_overrun <= 1'b1;
            if (wd_expired && !abort) err_timeout <= 1'b1;
            if (abort && abortable)   aborted     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_row_request_scheduler.sv
// Directed bench for row_request_scheduler with a small behavioural request-generator model.
module tb_row_request_scheduler;

    localparam int CNT_W = 64;
    localparam int TO    = 100;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] cfg_total_rows = '0;
    logic [31:0]      cfg_chunk_rows = '0;
    logic [15:0]      cfg_frames = '0;
    logic             gen_start;
    logic [CNT_W-1:0] gen_count;
    logic             gen_idle = 1'b1;
    logic             row_complete_in = 1'b0;
    logic             busy, done, aborted, err_cfg, err_timeout, err_overrun;
    logic [CNT_W-1:0] rows_done;
    logic [15:0]      frames_done;

    int n_checks = 0;
    int n_fail   = 0;

    row_request_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .cfg_total_rows(cfg_total_rows), .cfg_chunk_rows(cfg_chunk_rows), .cfg_frames(cfg_frames),
        .gen_start(gen_start), .gen_count(gen_count), .gen_idle(gen_idle),
        .row_complete_in(row_complete_in), .busy(busy), .done(done), .aborted(aborted),
        .err_cfg(err_cfg), .err_timeout(err_timeout), .err_overrun(err_overrun),
        .rows_done(rows_done), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: busy for 3 cycles after each gen_start, completions start 2 cycles later.
    int          gen_starts = 0, done_cnt = 0, pending = 0, busy_left = 0, comp_delay = 0;
    int          comp_emitted = 0, last_comp_cyc = 0;
    int          comp_limit = -1;
    bit          gen_hold = 1'b0;
    logic [63:0] counts_q[$];

    always @(negedge clk) begin
        row_complete_in = 1'b0;
        if (pending > 0) begin
            if (comp_delay > 0) comp_delay--;
            else if (comp_limit < 0 || comp_emitted < comp_limit) begin
                row_complete_in = 1'b1;
                pending--;
                comp_emitted++;
                last_comp_cyc = cyc;
            end
        end
        if (busy_left > 0) busy_left--;
        if (gen_start === 1'b1) begin
            gen_starts++;
            counts_q.push_back(gen_count);
            pending    = int'(gen_count);
            comp_delay = 2;
            busy_left  = 3;
        end
        gen_idle = (busy_left == 0) && !gen_hold;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] total, input logic [31:0] chunk, input logic [15:0] frames);
        @(negedge clk);
        cfg_total_rows = total;
        cfg_chunk_rows = chunk;
        cfg_frames     = frames;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {63'd0, busy}, 64'd0);
        @(negedge clk);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    int base_s, base_d, t3, n;

    initial begin
        // Reset state
        run_cycles(3);
        check("rst_busy",   {63'd0, busy}, 64'd0);
        check("rst_gen",    {63'd0, gen_start}, 64'd0);
        check("rst_count",  gen_count, 64'd0);
        check("rst_rows",   rows_done, 64'd0);
        check("rst_frames", {48'd0, frames_done}, 64'd0);
        check("rst_flags",  {58'd0, done, aborted, err_cfg, err_timeout, err_overrun, busy}, 64'd0);
        resetn = 1'b1;
        run_cycles(2);

        // Chunking: 20 rows in chunks of 8
        base_s = gen_starts; base_d = done_cnt;
        do_start(64'd20, 32'd8, 16'd1);
        wait_idle("t1_wait", 400);
        check("t1_starts", 64'(gen_starts - base_s), 64'd3);
        check("t1_cnt0",   counts_q[base_s],     64'd8);
        check("t1_cnt1",   counts_q[base_s + 1], 64'd8);
        check("t1_cnt2",   counts_q[base_s + 2], 64'd4);
        check("t1_done",   64'(done_cnt - base_d), 64'd1);
        check("t1_rows",   rows_done, 64'd20);
        check("t1_frames", {48'd0, frames_done}, 64'd1);
        check("t1_flags",  {60'd0, aborted, err_cfg, err_timeout, err_overrun}, 64'd0);
        check("t1_hold",   gen_count, 64'd4);

        // Frame repeat: 5 rows x 3 frames
        base_s = gen_starts; base_d = done_cnt;
        do_start(64'd5, 32'd8, 16'd3);
        wait_idle("t2_wait", 400);
        check("t2_starts", 64'(gen_starts - base_s), 64'd3);
        check("t2_cnt0",   counts_q[base_s],     64'd5);
        check("t2_cnt1",   counts_q[base_s + 1], 64'd5);
        check("t2_cnt2",   counts_q[base_s + 2], 64'd5);
        check("t2_done",   64'(done_cnt - base_d), 64'd1);
        check("t2_rows",   rows_done, 64'd15);
        check("t2_frames", {48'd0, frames_done}, 64'd3);

        // total = 0: done two cycles after start, never a gen_start
        base_s = gen_starts;
        do_start(64'd0, 32'd8, 16'd4);
        check("t3_done_early", {63'd0, done}, 64'd0);
        check("t3_busy",       {63'd0, busy}, 64'd1);
        @(negedge clk);
        check("t3_done",   {63'd0, done}, 64'd1);
        check("t3_frames", {48'd0, frames_done}, 64'd4);
        @(negedge clk);
        check("t3_starts", 64'(gen_starts - base_s), 64'd0);

        // chunk = 0 with rows pending: err_cfg, stays idle
        do_start(64'd4, 32'd0, 16'd1);
        check("t3b_err_cfg", {63'd0, err_cfg}, 64'd1);
        check("t3b_busy",    {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("t3b_busy2",   {63'd0, busy}, 64'd0);
        check("t3b_starts",  64'(gen_starts - base_s), 64'd0);

        // Timeout: only 3 of 4 completions delivered
        base_d = done_cnt;
        comp_limit = comp_emitted + 3;
        do_start(64'd4, 32'd4, 16'd1);
        n = 0;
        while (comp_emitted < comp_limit && n < 200) begin @(negedge clk); n++; end
        check("t4_comps", 64'(comp_limit - comp_emitted), 64'd0);
        t3 = last_comp_cyc;
        n = 0;
        while (cyc < t3 + TO && n < 300) begin @(negedge clk); n++; end
        check("t4_not_yet", {63'd0, err_timeout}, 64'd0);
        @(negedge clk);
        check("t4_timeout", {63'd0, err_timeout}, 64'd1);
        check("t4_busy",    {63'd0, busy}, 64'd0);
        check("t4_rows",    rows_done, 64'd3);
        check("t4_err_cfg", {63'd0, err_cfg}, 64'd0);
        @(negedge clk);
        check("t4_no_done", 64'(done_cnt - base_d), 64'd0);
        comp_limit = -1;
        run_cycles(6);

        // Abort while the generator is busy
        base_s = gen_starts; base_d = done_cnt;
        gen_hold = 1'b1;
        comp_limit = comp_emitted;
        do_start(64'd8, 32'd4, 16'd1);
        n = 0;
        while (gen_starts == base_s && n < 20) begin @(negedge clk); n++; end
        run_cycles(2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_aborted", {63'd0, aborted}, 64'd1);
        run_cycles(4);
        check("t5_busy_held", {63'd0, busy}, 64'd1);
        gen_hold = 1'b0;
        run_cycles(2);
        check("t5_busy_off", {63'd0, busy}, 64'd0);
        run_cycles(6);
        check("t5_starts", 64'(gen_starts - base_s), 64'd1);
        check("t5_done",   64'(done_cnt - base_d), 64'd0);

        // abort together with start: start ignored, flags untouched
        comp_limit = -1;
        run_cycles(8);
        base_s = gen_starts;
        @(negedge clk);
        cfg_total_rows = 64'd4; cfg_chunk_rows = 32'd4; cfg_frames = 16'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t6_busy", {63'd0, busy}, 64'd0);
        run_cycles(4);
        check("t6_starts",  64'(gen_starts - base_s), 64'd0);
        check("t6_aborted", {63'd0, aborted}, 64'd1);

        // Asynchronous reset during DRAIN, then stray completions
        do_start(64'd16, 32'd16, 16'd1);
        n = 0;
        while (rows_done < 64'd8 && n < 100) begin @(negedge clk); n++; end
        check("t7_reached", {63'd0, (rows_done >= 64'd8)}, 64'd1);
        base_s = gen_starts; base_d = done_cnt;
        #2 resetn = 1'b0;
        #1;
        check("t7_busy",   {63'd0, busy}, 64'd0);
        check("t7_rows",   rows_done, 64'd0);
        check("t7_count",  gen_count, 64'd0);
        check("t7_frames", {48'd0, frames_done}, 64'd0);
        check("t7_outs",   {61'd0, gen_start, done, aborted}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_cycles(12);
        check("t7_overrun", {63'd0, err_overrun}, 64'd0);
        check("t7_idle",    {63'd0, busy}, 64'd0);
        check("t7_starts",  64'(gen_starts - base_s), 64'd0);
        check("t7_done",    64'(done_cnt - base_d), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/row_request_scheduler.md
Name: row_request_scheduler

Overview:
- Sequences the AXIS row-request generator. A large row transfer is split into chunks of at most cfg_chunk_rows rows, and the whole transfer is repeated cfg_frames times.
- For each chunk the block:
  - pulses the generator's start input with that chunk's count;
  - waits for the generator to go idle;
  - waits for every row of the chunk to be reported complete before launching the next chunk.
- Sits between the AXI-lite control registers and the request generator, and also provides status and a completion watchdog.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: max cycles with no row_complete_in while rows are still outstanding. When exceeded, the block raises err_timeout.
- CNT_W, 64: width of row counters and of gen_count.

Ports:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a transfer. Honoured only in IDLE.
- abort  in  1  one-cycle pulse; stops issuing chunks.
- cfg_total_rows  in  CNT_W  rows per frame. Sampled at start.
- cfg_chunk_rows  in  32  max rows per chunk. Sampled at start.
- cfg_frames  in  16  number of frames. Sampled at start; 0 is treated as 1.
- gen_start  out  1  one-cycle pulse to the generator.
- gen_count  out  CNT_W  row count for the chunk; valid while gen_start is high and held until the next gen_start.
- gen_idle  in  1  generator idle indicator.
- row_complete_in  in  1  one pulse per fulfilled row.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when all frames complete normally.
- aborted  out  1  sticky; cleared on start.
- err_cfg  out  1  sticky; cleared on start.
- err_timeout  out  1  sticky; cleared on start.
- err_overrun  out  1  sticky; cleared on start.
- rows_done  out  CNT_W  rows completed in the current/last transfer.
- frames_done  out  16  frames completed.

Behaviour:
- Reset: every register and output is 0 (gen_count, rows_done and frames_done included), and state is IDLE. Reset may be asserted in any state with the same result; no gen_start or done pulse may follow it.
- Registers on reset: all state registers use the asynchronous active-low resetn.
- Accepting start (IDLE only):
  - clear the sticky flags, rows_done and frames_done;
  - latch the cfg_* inputs;
  - set remaining = cfg_total_rows.
- Start rejection and degenerate cases:
  - cfg_chunk_rows == 0 with cfg_total_rows != 0: set err_cfg and stay IDLE.
  - cfg_total_rows == 0: go to DONE, which pulses done the next cycle with frames_done = frames.
  - Otherwise go to LAUNCH.
- States:
  - LAUNCH (one cycle):
    - chunk = min(remaining, chunk_rows);
    - drive gen_start = 1 and gen_count = chunk on the same registered cycle;
    - set remaining -= chunk and chunk_outstanding = chunk;
    - go to WAIT_ACK.
    - Latency from start to gen_start is 2 cycles.
  - WAIT_ACK: when gen_idle == 0, go to WAIT_GEN.
  - WAIT_GEN: when gen_idle == 1, go to DRAIN.
  - DRAIN: when chunk_outstanding == 0 (including on entry), go to NEXT.
  - NEXT (one cycle):
    - if remaining != 0, go to LAUNCH;
    - otherwise frames_done += 1;
    - if frames_done + 1 == frames, go to DONE; otherwise reload remaining = total_rows and go to LAUNCH.
  - DONE (one cycle): pulse done, go to IDLE.
- Completion counting:
  - row_complete_in is counted in WAIT_ACK, WAIT_GEN and DRAIN: chunk_outstanding -= 1 and rows_done += 1.
  - Completions arriving before the generator goes idle are legal.
  - row_complete_in while chunk_outstanding == 0, or while IDLE: ignored, and err_overrun is set if busy.
  - A single completion on the same cycle as the transition into NEXT is still counted.
- Watchdog:
  - The counter runs in WAIT_ACK, WAIT_GEN and DRAIN.
  - It resets on each row_complete_in and on entry to LAUNCH.
  - On reaching TIMEOUT_CYCLES: set err_timeout and go to IDLE with no done pulse.
- Abort:
  - LAUNCH/NEXT/DRAIN: go to IDLE the next cycle.
  - WAIT_ACK/WAIT_GEN: go to ABORT_WAIT, which leaves for IDLE once gen_idle == 1 and WAIT_ACK has been passed. The generator has no stop input, so the block waits for it to go idle.
  - In every case set aborted and emit no done pulse.
  - abort in IDLE has no effect.
  - abort on the same cycle as start: abort wins and start is ignored.
- Widths and wrap: counters never wrap. total_rows is limited to 2^CNT_W − 1, and the chunk is zero-extended to CNT_W.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LAUNCH, WAIT_ACK, WAIT_GEN, DRAIN, NEXT, DONE, ABORT_WAIT);
  - the default timeout value;
  - CNT_W;
  - the MAX_OUTSTANDING_REQUESTS constant used by the generator.
- One sub-module, sched_watchdog: a loadable timeout counter with inputs clear and enable and output expired.

Test Plan:
- Chunking: total=20, chunk=8, frames=1, completions 2 cycles after each request.
  - gen_start ×3 with gen_count 8, 8, 4.
  - done pulses once, rows_done=20, frames_done=1, no error flags.
- Frame repeat: total=5, chunk=8, frames=3.
  - gen_start ×3, each with gen_count=5.
  - done after 15 completions, frames_done=3.
- Degenerate configuration:
  - total=0: done pulses 2 cycles after start, gen_start is never asserted, frames_done = frames.
  - chunk=0, total=4: err_cfg=1, busy stays 0.
- Timeout: TIMEOUT_CYCLES=100, total=4, chunk=4, only 3 completions supplied.
  - err_timeout=1 exactly 100 cycles after the 3rd completion.
  - busy=0, no done pulse, rows_done=3.
- Abort while the generator is busy: abort in WAIT_GEN.
  - busy stays 1 until gen_idle rises, then 0.
  - aborted=1, no further gen_start, no done.
- Reset during DRAIN: assert resetn=0 asynchronously mid-cycle.
  - All outputs read 0 immediately.
  - After release, stray row_complete_in pulses do not set err_overrun.
